// File: rtl/adc_remap_pkg.sv
// adc_remap_pkg: lane map types, board routing table and permutation check for adc_lane_remap
package adc_remap_pkg;
    localparam int NUM_CH = 8;
    localparam int LANES = 8;
    localparam int LIDX_W = $clog2(LANES);
    typedef logic [LANES-1:0][LIDX_W-1:0] lane_map_t;
    typedef enum logic [1:0] {IDLE, CHECK, APPLY, REJECT} fsm_t;
    // board routing swaps lanes by XORing every lane index with a per-bus constant
    function automatic lane_map_t xmap(int x);
        lane_map_t m;
        for (int k = 0; k < LANES; k++) m[k] = LIDX_W'(k ^ x);
        return m;
    endfunction
    localparam lane_map_t BOARD_MAP [NUM_CH][2] = '{
        '{xmap(0), xmap(0)},
        '{xmap(1), xmap(3)},
        '{xmap(2), xmap(6)},
        '{xmap(3), xmap(1)},
        '{xmap(0), xmap(0)},
        '{xmap(5), xmap(7)},
        '{xmap(6), xmap(2)},
        '{xmap(7), xmap(5)}
    };
    function automatic logic is_perm(lane_map_t m);
        logic [LANES-1:0] seen;
        seen = '0;
        for (int k = 0; k < LANES; k++) seen[m[k]] = 1'b1;
        return &seen;
    endfunction
endpackage

// File: rtl/adc_lane_perm.sv
// adc_lane_perm: combinational single-bus lane permute, dout[k] = din[map[k]]
module adc_lane_perm
    import adc_remap_pkg::*;
(
    input  logic [LANES-1:0] din,
    input  lane_map_t        map,
    output logic [LANES-1:0] dout
);
    always_comb begin
        dout = '0;
        for (int k = 0; k < LANES; k++) dout[k] = din[map[k]];
    end
endmodule

// File: rtl/adc_lane_remap.sv
// adc_lane_remap: run-time programmable P/N lane remapper with shadow/active banks and permutation checker
module adc_lane_remap
    import adc_remap_pkg::*;
#(
    parameter int N_CH = NUM_CH,
    parameter int W = LANES,
    parameter int IDX_W = $clog2(W)
)(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic [N_CH-1:0][W-1:0]       in_i_p,
    input  logic [N_CH-1:0][W-1:0]       in_i_n,
    input  logic [N_CH-1:0][W-1:0]       in_q_p,
    input  logic [N_CH-1:0][W-1:0]       in_q_n,
    input  logic                         cfg_we,
    input  logic [$clog2(N_CH)-1:0]      cfg_ch,
    input  logic                         cfg_sel,
    input  logic [W-1:0][IDX_W-1:0]      cfg_map,
    input  logic                         cfg_commit,
    output logic                         cfg_busy,
    output logic                         commit_ack,
    output logic                         commit_err,
    output logic [$clog2(2*N_CH)-1:0]    err_idx,
    output logic                         cfg_drop,
    output logic                         out_valid,
    output logic [N_CH-1:0][W-1:0]       out_i_p,
    output logic [N_CH-1:0][W-1:0]       out_i_n,
    output logic [N_CH-1:0][W-1:0]       out_q_p,
    output logic [N_CH-1:0][W-1:0]       out_q_n
);
    localparam int EW = $clog2(2*N_CH);
    fsm_t state;
    lane_map_t shadow [N_CH][2];
    lane_map_t active [N_CH][2];
    logic [EW-1:0] idx;
    logic fail, bad, last;
    logic [N_CH-1:0][W-1:0] pi_p, pi_n, pq_p, pq_n;
    assign cfg_busy = state != IDLE;
    assign bad = !is_perm(shadow[idx[EW-1:1]][idx[0]]);
    assign last = idx == EW'(2*N_CH-1);
    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        adc_lane_perm u_ip (.din(in_i_p[c]), .map(active[c][0]), .dout(pi_p[c]));
        adc_lane_perm u_in (.din(in_i_n[c]), .map(active[c][0]), .dout(pi_n[c]));
        adc_lane_perm u_qp (.din(in_q_p[c]), .map(active[c][1]), .dout(pq_p[c]));
        adc_lane_perm u_qn (.din(in_q_n[c]), .map(active[c][1]), .dout(pq_n[c]));
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx <= '0;
            fail <= 1'b0;
            err_idx <= '0;
            commit_ack <= 1'b0;
            commit_err <= 1'b0;
            cfg_drop <= 1'b0;
            for (int c = 0; c < N_CH; c++)
                for (int s = 0; s < 2; s++) begin
                    shadow[c][s] <= BOARD_MAP[c][s];
                    active[c][s] <= BOARD_MAP[c][s];
                end
        end else begin
            commit_ack <= 1'b0;
            commit_err <= 1'b0;
            cfg_drop <= cfg_busy && (cfg_we || cfg_commit);
            case (state)
                IDLE: begin
                    if (cfg_we) shadow[cfg_ch][cfg_sel] <= cfg_map;
                    if (cfg_commit) begin
                        state <= CHECK;
                        idx <= '0;
                        fail <= 1'b0;
                        err_idx <= '0;
                    end
                end
                CHECK: begin
                    idx <= idx + 1'b1;
                    if (bad) fail <= 1'b1;
                    if (bad && !fail) err_idx <= idx;
                    // pulses are raised on entry so they line up with the APPLY/REJECT cycle
                    if (last) begin
                        state <= (fail || bad) ? REJECT : APPLY;
                        commit_ack <= !(fail || bad);
                        commit_err <= fail || bad;
                    end
                end
                APPLY: begin
                    active <= shadow;
                    state <= IDLE;
                end
                REJECT: begin
                    shadow <= active;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_i_p <= '0;
            out_i_n <= '0;
            out_q_p <= '0;
            out_q_n <= '0;
        end else begin
            out_valid <= in_valid;
            out_i_p <= pi_p;
            out_i_n <= pi_n;
            out_q_p <= pq_p;
            out_q_n <= pq_n;
        end
    end
endmodule

// File: tb/tb_adc_lane_remap.sv
// tb_adc_lane_remap: randomized lane stream checked against a per-channel lane-table model
module tb_adc_lane_remap;
    logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0;
    logic [7:0][7:0] in_i_p = '0, in_i_n = '0, in_q_p = '0, in_q_n = '0;
    logic cfg_we = 1'b0, cfg_sel = 1'b0, cfg_commit = 1'b0;
    logic [2:0] cfg_ch = '0;
    logic [7:0][2:0] cfg_map = '0;
    logic cfg_busy, commit_ack, commit_err, cfg_drop, out_valid;
    logic [3:0] err_idx;
    logic [7:0][7:0] out_i_p, out_i_n, out_q_p, out_q_n;
    int n_pass = 0, n_total = 0, n_fail = 0;
    int act [8][2][8];
    int shd [8][2][8];
    int bx [8][2] = '{'{0, 0}, '{1, 3}, '{2, 6}, '{3, 1}, '{0, 0}, '{5, 7}, '{6, 2}, '{7, 5}};
    logic [7:0][2:0] rev, badm, pm;
    int p [8];

    always #5 clk = ~clk;

    adc_lane_remap dut (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .in_i_p(in_i_p), .in_i_n(in_i_n), .in_q_p(in_q_p), .in_q_n(in_q_n),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_sel(cfg_sel), .cfg_map(cfg_map),
        .cfg_commit(cfg_commit), .cfg_busy(cfg_busy), .commit_ack(commit_ack),
        .commit_err(commit_err), .err_idx(err_idx), .cfg_drop(cfg_drop),
        .out_valid(out_valid), .out_i_p(out_i_p), .out_i_n(out_i_n),
        .out_q_p(out_q_p), .out_q_n(out_q_n)
    );

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(string tag, logic obs, logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] remap(logic [63:0] bus, int s);
        logic [63:0] r;
        r = '0;
        for (int c = 0; c < 8; c++)
            for (int k = 0; k < 8; k++) r[c*8+k] = bus[c*8+act[c][s][k]];
        return r;
    endfunction

    task automatic load_board();
        for (int c = 0; c < 8; c++)
            for (int s = 0; s < 2; s++)
                for (int k = 0; k < 8; k++) act[c][s][k] = k ^ bx[c][s];
        shd = act;
    endtask

    task automatic rand_in();
        in_valid = 1'($urandom_range(0, 1));
        in_i_p = {$urandom, $urandom};
        in_i_n = {$urandom, $urandom};
        in_q_p = {$urandom, $urandom};
        in_q_n = {$urandom, $urandom};
    endtask

    task automatic tick();
        logic [63:0] e_ip, e_in, e_qp, e_qn;
        logic ev;
        e_ip = rst ? '0 : remap(in_i_p, 0);
        e_in = rst ? '0 : remap(in_i_n, 0);
        e_qp = rst ? '0 : remap(in_q_p, 1);
        e_qn = rst ? '0 : remap(in_q_n, 1);
        ev = rst ? 1'b0 : in_valid;
        @(posedge clk);
        #1;
        chk("out_i_p", out_i_p, e_ip);
        chk("out_i_n", out_i_n, e_in);
        chk("out_q_p", out_q_p, e_qp);
        chk("out_q_n", out_q_n, e_qn);
        chk1("out_valid", out_valid, ev);
        rand_in();
    endtask

    task automatic wr(int c, int s, logic [7:0][2:0] m);
        cfg_we = 1'b1;
        cfg_ch = 3'(c);
        cfg_sel = 1'(s);
        cfg_map = m;
        for (int k = 0; k < 8; k++) shd[c][s][k] = int'(m[k]);
    endtask

    // commit, then walk the 17 busy cycles, optionally poking cfg_we/cfg_commit mid-check
    task automatic commit_seq(logic ok, int we_at, int cm_at);
        cfg_commit = 1'b1;
        tick();
        cfg_we = 1'b0;
        cfg_commit = 1'b0;
        for (int n = 1; n <= 17; n++) begin
            chk1("busy", cfg_busy, 1'b1);
            chk1("ack", commit_ack, ok && n == 17);
            chk1("err", commit_err, !ok && n == 17);
            chk1("drop", cfg_drop, n > 1 && (n - 1 == we_at || n - 1 == cm_at));
            cfg_we = n == we_at;
            cfg_commit = n == cm_at;
            if (n == we_at) begin
                cfg_ch = 3'd1;
                cfg_sel = 1'b0;
                cfg_map = '0;
            end
            tick();
            cfg_we = 1'b0;
            cfg_commit = 1'b0;
            if (n == 17) begin
                if (ok) act = shd;
                else shd = act;
            end
        end
        chk1("busy_done", cfg_busy, 1'b0);
        chk1("ack_done", commit_ack, 1'b0);
        chk1("err_done", commit_err, 1'b0);
        chk1("drop_done", cfg_drop, 1'b0);
    endtask

    initial begin
        load_board();
        rand_in();
        tick();
        tick();
        chk1("rst_busy", cfg_busy, 1'b0);
        chk("rst_err_idx", 64'(err_idx), 64'd0);
        chk1("rst_ack", commit_ack, 1'b0);
        rst = 1'b0;
        in_valid = 1'b1;
        in_i_p[0] = 8'hA5;
        tick();
        chk("ch0_identity", 64'(out_i_p[0]), 64'hA5);
        chk1("valid_a5", out_valid, 1'b1);
        repeat (4) tick();
        for (int k = 0; k < 8; k++) rev[k] = 3'(7 - k);
        wr(2, 0, rev);
        tick();
        cfg_we = 1'b0;
        commit_seq(1'b1, 0, 0);
        in_i_p[2] = 8'h01;
        tick();
        chk("rev_ch2", 64'(out_i_p[2]), 64'h80);
        for (int k = 0; k < 8; k++) badm[k] = 3'(k);
        badm[6] = 3'd3;
        wr(6, 0, '0);
        tick();
        wr(5, 1, badm);
        commit_seq(1'b0, 0, 0);
        chk("err_idx", 64'(err_idx), 64'd11);
        repeat (3) tick();
        chk("err_idx_held", 64'(err_idx), 64'd11);
        commit_seq(1'b1, 0, 0);
        for (int k = 0; k < 8; k++) p[k] = k;
        for (int i = 7; i > 0; i--) begin
            int j, t;
            j = int'($urandom_range(0, i));
            t = p[i];
            p[i] = p[j];
            p[j] = t;
        end
        for (int k = 0; k < 8; k++) pm[k] = 3'(p[k]);
        wr(3, 1, pm);
        tick();
        cfg_we = 1'b0;
        commit_seq(1'b1, 3, 5);
        repeat (3) tick();
        wr(7, 0, rev);
        tick();
        cfg_we = 1'b0;
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        for (int n = 1; n <= 4; n++) begin
            chk1("busy_pre_rst", cfg_busy, 1'b1);
            tick();
        end
        rst = 1'b1;
        tick();
        load_board();
        rst = 1'b0;
        for (int n = 0; n < 20; n++) begin
            chk1("post_rst_busy", cfg_busy, 1'b0);
            chk1("post_rst_ack", commit_ack, 1'b0);
            chk1("post_rst_err", commit_err, 1'b0);
            tick();
        end
        commit_seq(1'b1, 0, 0);
        repeat (5) tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
